cluster_frame_builder: RTL and testbench

//  Downstream of the dual-encoder cluster mux. Collects the 8 cnt/adr cluster slots the mux presents each clock4x cycle.

---
 rtl/cluster_frame_builder.sv | 127 ++++++++++++
 tb/tb_cluster_frame_builder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_frame_builder.sv
// Collects up to MAX_CLUSTERS valid cnt/adr clusters per bunch crossing and emits them as one registered frame.
// Optional saturating overflowed-frame counter on port ovf_frames when CLUSTER_FRAME_OVF_CNT_EN is defined.
module cluster_frame_builder #(
  parameter int unsigned MAX_CLUSTERS = 8,
  parameter logic [10:0] INVALID_ADR  = 11'h7FE,
  parameter int unsigned PHASES       = 4
) (
  input  logic                       clock4x,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [23:0]                cnt_in,
  input  logic [87:0]                adr_in,
  output logic                       frame_valid,
  output logic [MAX_CLUSTERS*14-1:0] clusters_out,
  output logic [3:0]                 cluster_count,
  output logic                       overflow,
  output logic                       sync_err
`ifdef CLUSTER_FRAME_OVF_CNT_EN
  ,
  output logic [15:0]                ovf_frames
`endif
);

  localparam int unsigned SLOTS      = 8;
  localparam int unsigned PW         = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned IW         = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
  localparam logic [3:0]  MAX_FILL   = 4'(MAX_CLUSTERS);
  localparam logic [10:0] ADR_LIMIT  = 11'd1536;
  localparam logic [13:0] EMPTY_WORD = {3'd0, INVALID_ADR};

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic [13:0]   buf_q [MAX_CLUSTERS];
  logic [13:0]   buf_d [MAX_CLUSTERS];
  logic [13:0]   out_q [MAX_CLUSTERS];
  logic [3:0]    fill_q;
  logic [3:0]    fill_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          misaligned;
  logic          close;

  always_comb begin
    misaligned = frame_start && (phase_q != LAST_PHASE);
    if (frame_start || (phase_q == LAST_PHASE)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
    close = (phase_d == LAST_PHASE);
  end

  // A misaligned frame_start drops the partial frame before this cycle's slots are appended.
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    if (misaligned) begin
      for (int unsigned j = 0; j < MAX_CLUSTERS; j++) begin
        buf_d[j] = EMPTY_WORD;
      end
      fill_d = '0;
      ovf_d  = 1'b0;
    end
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (adr_in[11*k +: 11] < ADR_LIMIT) begin
        if (fill_d < MAX_FILL) begin
          buf_d[fill_d[IW-1:0]] = {cnt_in[3*k +: 3], adr_in[11*k +: 11]};
          fill_d = fill_d + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      phase_q       <= LAST_PHASE;
      fill_q        <= '0;
      ovf_q         <= 1'b0;
      frame_valid   <= 1'b0;
      cluster_count <= '0;
      overflow      <= 1'b0;
      sync_err      <= 1'b0;
      for (int unsigned j = 0; j < MAX_CLUSTERS; j++) begin
        buf_q[j] <= EMPTY_WORD;
        out_q[j] <= EMPTY_WORD;
      end
    end else begin
      phase_q     <= phase_d;
      sync_err    <= misaligned;
      frame_valid <= close;
      if (close) begin
        // Frame closes and the buffer restarts on the same edge, so no input cycle is lost.
        out_q         <= buf_d;
        cluster_count <= fill_d;
        overflow      <= ovf_d;
        fill_q        <= '0;
        ovf_q         <= 1'b0;
        for (int unsigned j = 0; j < MAX_CLUSTERS; j++) begin
          buf_q[j] <= EMPTY_WORD;
        end
      end else begin
        buf_q  <= buf_d;
        fill_q <= fill_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  for (genvar j = 0; j < MAX_CLUSTERS; j++) begin : g_pack
    assign clusters_out[14*j +: 14] = out_q[j];
  end

`ifdef CLUSTER_FRAME_OVF_CNT_EN
  always_ff @(posedge clock4x) begin
    if (reset) begin
      ovf_frames <= '0;
    end else if (close && ovf_d && (ovf_frames != '1)) begin
      ovf_frames <= ovf_frames + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cluster_frame_builder.sv
// Directed bench for cluster_frame_builder: alignment, ordering, overflow, resync and reset behaviour.
module tb_cluster_frame_builder;

  logic         clock4x = 1'b0;
  logic         reset;
  logic         frame_start;
  logic [23:0]  cnt_in;
  logic [87:0]  adr_in;
  logic         frame_valid;
  logic [111:0] clusters_out;
  logic [3:0]   cluster_count;
  logic         overflow;
  logic         sync_err;
`ifdef CLUSTER_FRAME_OVF_CNT_EN
  logic [15:0]  ovf_frames;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [13:0] exp_w [8];

  cluster_frame_builder #(
    .MAX_CLUSTERS(8),
    .INVALID_ADR (11'h7FE),
    .PHASES      (4)
  ) dut (
    .clock4x      (clock4x),
    .reset        (reset),
    .frame_start  (frame_start),
    .cnt_in       (cnt_in),
    .adr_in       (adr_in),
    .frame_valid  (frame_valid),
    .clusters_out (clusters_out),
    .cluster_count(cluster_count),
    .overflow     (overflow),
    .sync_err     (sync_err)
`ifdef CLUSTER_FRAME_OVF_CNT_EN
    ,
    .ovf_frames   (ovf_frames)
`endif
  );

  always #5 clock4x = ~clock4x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_slots();
    cnt_in = '0;
    adr_in = {8{11'h7FE}};
  endtask

  task automatic set_slot(input int k, input int c, input int a);
    cnt_in[3*k +: 3]  = 3'(c);
    adr_in[11*k +: 11] = 11'(a);
  endtask

  // Apply the current slots for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic fs);
    frame_start = fs;
    @(posedge clock4x);
    #1;
    frame_start = 1'b0;
    clear_slots();
  endtask

  task automatic exp_empty();
    for (int j = 0; j < 8; j++) exp_w[j] = {3'd0, 11'h7FE};
  endtask

  task automatic check_words(input string tag);
    for (int j = 0; j < 8; j++) begin
      check_eq($sformatf("%s_w%0d", tag, j), 32'(clusters_out[14*j +: 14]), 32'(exp_w[j]));
    end
  endtask

  task automatic check_frame(input string tag, input int fv, input int cnt, input int ovf);
    check_eq({tag, "_fv"}, 32'(frame_valid), 32'(fv));
    check_eq({tag, "_count"}, 32'(cluster_count), 32'(cnt));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    check_words(tag);
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    clear_slots();
    step(1'b0);
    step(1'b0);
    reset = 1'b0;

    // Reset state
    exp_empty();
    check_frame("rst", 0, 0, 0);
    check_eq("rst_sync", 32'(sync_err), 32'd0);
`ifdef CLUSTER_FRAME_OVF_CNT_EN
    check_eq("rst_ovfcnt", 32'(ovf_frames), 32'd0);
`endif

    // 1: empty aligned frame
    step(1'b1);
    check_eq("t1_sync", 32'(sync_err), 32'd0);
    check_eq("t1_p0_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    check_eq("t1_p1_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    check_eq("t1_p2_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    check_frame("t1", 1, 0, 0);

    // 2: scattered clusters, adr 1535 valid, invalid slot cnt ignored
    set_slot(2, 3, 100);
    set_slot(1, 5, 11'h7FF);
    step(1'b1);
    check_eq("t2_sync", 32'(sync_err), 32'd0);
    check_eq("t2_p0_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    set_slot(0, 1, 5);
    set_slot(7, 7, 1535);
    step(1'b0);
    step(1'b0);
    exp_empty();
    exp_w[0] = {3'd3, 11'd100};
    exp_w[1] = {3'd1, 11'd5};
    exp_w[2] = {3'd7, 11'd1535};
    check_frame("t2", 1, 3, 0);

    // 3: 8 valid in phase 0 plus one more in phase 3 -> overflow
    for (int k = 0; k < 8; k++) set_slot(k, k, 10 + k);
    step(1'b0);
    check_eq("t2_hold_fv", 32'(frame_valid), 32'd0);
    check_eq("t2_hold_count", 32'(cluster_count), 32'd3);
    step(1'b0);
    step(1'b0);
    set_slot(5, 2, 200);
    step(1'b0);
    for (int k = 0; k < 8; k++) exp_w[k] = {3'(k), 11'(10 + k)};
    check_frame("t3", 1, 8, 1);
`ifdef CLUSTER_FRAME_OVF_CNT_EN
    check_eq("t3_ovfcnt", 32'(ovf_frames), 32'd1);
`endif

    // 4: exactly full, 5 in phase 1 and 3 in phase 3
    step(1'b0);
    check_eq("t3_hold_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 5; k++) set_slot(k, 1, 20 + k);
    step(1'b0);
    step(1'b0);
    set_slot(1, 4, 301);
    set_slot(3, 4, 303);
    set_slot(6, 4, 306);
    step(1'b0);
    for (int k = 0; k < 5; k++) exp_w[k] = {3'd1, 11'(20 + k)};
    exp_w[5] = {3'd4, 11'd301};
    exp_w[6] = {3'd4, 11'd303};
    exp_w[7] = {3'd4, 11'd306};
    check_frame("t4", 1, 8, 0);
`ifdef CLUSTER_FRAME_OVF_CNT_EN
    check_eq("t4_ovfcnt", 32'(ovf_frames), 32'd1);
`endif

    // 5: misaligned frame_start at phase 1 discards pending cluster
    set_slot(0, 2, 50);
    step(1'b0);
    check_eq("t5_p0_sync", 32'(sync_err), 32'd0);
    set_slot(3, 5, 60);
    step(1'b1);
    check_eq("t5_sync_pulse", 32'(sync_err), 32'd1);
    check_eq("t5_n0_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    check_eq("t5_sync_clear", 32'(sync_err), 32'd0);
    check_eq("t5_n1_fv", 32'(frame_valid), 32'd0);
    set_slot(1, 6, 70);
    step(1'b0);
    check_eq("t5_n2_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    exp_empty();
    exp_w[0] = {3'd5, 11'd60};
    exp_w[1] = {3'd6, 11'd70};
    check_frame("t5", 1, 2, 0);

    // 6: reset at phase 2 with 4 clusters buffered
    set_slot(0, 1, 1);
    set_slot(1, 1, 2);
    step(1'b0);
    set_slot(0, 1, 3);
    set_slot(1, 1, 4);
    step(1'b0);
    reset = 1'b1;
    set_slot(2, 2, 9);
    step(1'b0);
    reset = 1'b0;
    exp_empty();
    check_frame("t6_rst", 0, 0, 0);
    check_eq("t6_rst_sync", 32'(sync_err), 32'd0);
`ifdef CLUSTER_FRAME_OVF_CNT_EN
    check_eq("t6_rst_ovfcnt", 32'(ovf_frames), 32'd0);
`endif
    set_slot(0, 1, 1536);
    set_slot(4, 3, 1534);
    step(1'b1);
    check_eq("t6_p0_fv", 32'(frame_valid), 32'd0);
    check_eq("t6_p0_sync", 32'(sync_err), 32'd0);
    step(1'b0);
    check_eq("t6_p1_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    check_eq("t6_p2_fv", 32'(frame_valid), 32'd0);
    step(1'b0);
    exp_w[0] = {3'd3, 11'd1534};
    check_frame("t6", 1, 1, 0);
    step(1'b0);
    check_eq("t6_strobe_end", 32'(frame_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
